pipeline_flow_ctrl: RTL and testbench

- Parametrised pipeline-register chain with centralised stall, bubble, flush and halt handling for the CPU's inter-stage registers.
- Replaces the per-register flush/stall muxing that is currently hand-written around the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Generalises that muxing to NUM_REGS boundary registers of DATA_W payload each.
- Adds a global run/halt gate and saturating stall/flush event counters for bring-up.

---
 rtl/pipeline_flow_ctrl_if.sv | 24 ++
 rtl/pipeline_flow_ctrl.sv | 87 ++++++++
 tb/tb_pipeline_flow_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_flow_ctrl_if.sv
// Handshake and stage-view bundle between the fetch/hazard logic and the
// pipeline boundary-register chain.
interface pipeline_flow_ctrl_if #(
  parameter int NUM_REGS = 4,
  parameter int DATA_W   = 32
);
  logic                       in_valid;
  logic [DATA_W-1:0]          in_data;
  logic                       in_ready;
  logic [NUM_REGS-1:0]        stall_req;
  logic [NUM_REGS-1:0]        flush_req;
  logic [NUM_REGS-1:0]        stage_valid;
  logic [NUM_REGS*DATA_W-1:0] stage_data;

  modport master (
    output in_valid, in_data, stall_req, flush_req,
    input  in_ready, stage_valid, stage_data
  );

  modport slave (
    input  in_valid, in_data, stall_req, flush_req,
    output in_ready, stage_valid, stage_data
  );
endinterface

// File: rtl/pipeline_flow_ctrl.sv
// Pipeline boundary-register chain with centralised stall, bubble, flush and
// halt handling, plus saturating stall/flush event counters.
module pipeline_flow_ctrl #(
  parameter int NUM_REGS = 4,
  parameter int DATA_W   = 32,
  parameter int COUNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run_en,
  pipeline_flow_ctrl_if.slave  bus,
  output logic [COUNT_W-1:0]   stall_cnt,
  output logic [COUNT_W-1:0]   flush_cnt
);

  logic [NUM_REGS-1:0] vld;
  logic [DATA_W-1:0]   dat [NUM_REGS];
  int                  s_idx;
  int                  f_idx;
  logic                s_any;
  logic                f_any;
  logic                stall_apply;
  logic                flush_apply;

  // Only the oldest request of each kind matters, so the last hit wins.
  always_comb begin
    s_idx = 0;
    f_idx = 0;
    s_any = 1'b0;
    f_any = 1'b0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (bus.stall_req[k]) begin
        s_idx = k;
        s_any = 1'b1;
      end
      if (bus.flush_req[k]) begin
        f_idx = k;
        f_any = 1'b1;
      end
    end
  end

  assign stall_apply  = run_en && s_any && (!f_any || (s_idx >= f_idx));
  assign flush_apply  = run_en && f_any && !stall_apply;
  assign bus.in_ready = run_en && !stall_apply && !flush_apply;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld       <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
      for (int k = 0; k < NUM_REGS; k++) begin
        dat[k] <= '0;
      end
    end else if (run_en) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (stall_apply && (k <= s_idx)) begin
          vld[k] <= vld[k];
          dat[k] <= dat[k];
        end else if ((stall_apply && (k == s_idx + 1)) || (flush_apply && (k <= f_idx))) begin
          vld[k] <= 1'b0;
          dat[k] <= '0;
        end else if (k == 0) begin
          // Reached only on a plain advance; stall/flush always cover R[0].
          vld[0] <= bus.in_valid;
          dat[0] <= bus.in_valid ? bus.in_data : '0;
        end else begin
          vld[k] <= vld[k-1];
          dat[k] <= dat[k-1];
        end
      end
      if (stall_apply && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + COUNT_W'(1);
      end
      if (flush_apply && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + COUNT_W'(1);
      end
    end
  end

  assign bus.stage_valid = vld;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_stage_data
    assign bus.stage_data[g*DATA_W +: DATA_W] = dat[g];
  end

endmodule

// File: tb/tb_pipeline_flow_ctrl.sv
// Scoreboard bench for pipeline_flow_ctrl: a behavioural model predicts every
// edge; directed scenarios add explicit end-state checks.
module tb_pipeline_flow_ctrl;
  localparam int NR = 4;
  localparam int DW = 32;
  localparam int CW = 16;

  typedef struct {
    logic [NR-1:0]    vld;
    logic [NR*DW-1:0] data;
    logic [CW-1:0]    sc;
    logic [CW-1:0]    fc;
    logic [2:0]       sc3;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic run_en = 1'b0;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [2:0]    stall_cnt3, flush_cnt3;

  pipeline_flow_ctrl_if #(.NUM_REGS(NR), .DATA_W(DW)) bus ();
  pipeline_flow_ctrl_if #(.NUM_REGS(NR), .DATA_W(DW)) bus3 ();

  assign bus3.in_valid  = bus.in_valid;
  assign bus3.in_data   = bus.in_data;
  assign bus3.stall_req = bus.stall_req;
  assign bus3.flush_req = bus.flush_req;

  pipeline_flow_ctrl #(.NUM_REGS(NR), .DATA_W(DW), .COUNT_W(CW)) dut (
    .clk(clk), .reset(reset), .run_en(run_en), .bus(bus),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_flow_ctrl #(.NUM_REGS(NR), .DATA_W(DW), .COUNT_W(3)) dut3 (
    .clk(clk), .reset(reset), .run_en(run_en), .bus(bus3),
    .stall_cnt(stall_cnt3), .flush_cnt(flush_cnt3)
  );

  always #5 clk = ~clk;

  exp_t          q[$];
  logic          m_vld [NR];
  logic [DW-1:0] m_dat [NR];
  int            m_sc, m_fc, m_sc3;
  int            checks = 0;
  int            errors = 0;

  task automatic model_predict(output exp_t e, output logic rdy);
    int s, f;
    logic do_stall, do_flush;
    logic          nv [NR];
    logic [DW-1:0] nd [NR];
    s = -1;
    f = -1;
    for (int k = 0; k < NR; k++) begin
      if (bus.stall_req[k]) s = k;
      if (bus.flush_req[k]) f = k;
    end
    do_stall = run_en && (s >= 0) && ((f < 0) || (s >= f));
    do_flush = run_en && (f >= 0) && !do_stall;
    rdy = run_en && !do_stall && !do_flush;
    for (int k = 0; k < NR; k++) begin
      nv[k] = m_vld[k];
      nd[k] = m_dat[k];
    end
    if (reset) begin
      for (int k = 0; k < NR; k++) begin
        nv[k] = 1'b0;
        nd[k] = '0;
      end
      m_sc = 0; m_fc = 0; m_sc3 = 0;
    end else if (run_en) begin
      for (int k = 0; k < NR; k++) begin
        if (do_stall) begin
          if (k == s + 1) begin
            nv[k] = 1'b0; nd[k] = '0;
          end else if (k > s + 1) begin
            nv[k] = m_vld[k-1]; nd[k] = m_dat[k-1];
          end
        end else if (do_flush) begin
          if (k <= f) begin
            nv[k] = 1'b0; nd[k] = '0;
          end else begin
            nv[k] = m_vld[k-1]; nd[k] = m_dat[k-1];
          end
        end else if (k == 0) begin
          nv[0] = bus.in_valid;
          nd[0] = bus.in_valid ? bus.in_data : '0;
        end else begin
          nv[k] = m_vld[k-1]; nd[k] = m_dat[k-1];
        end
      end
      if (do_stall) begin
        if (m_sc < 65535) m_sc++;
        if (m_sc3 < 7) m_sc3++;
      end
      if (do_flush && m_fc < 65535) m_fc++;
    end
    for (int k = 0; k < NR; k++) begin
      m_vld[k] = nv[k];
      m_dat[k] = nd[k];
      e.vld[k] = nv[k];
      e.data[k*DW +: DW] = nd[k];
    end
    e.sc  = CW'(m_sc);
    e.fc  = CW'(m_fc);
    e.sc3 = 3'(m_sc3);
  endtask

  task automatic cycle();
    exp_t e, x;
    logic rdy;
    #1;
    model_predict(e, rdy);
    q.push_back(e);
    checks++;
    if (bus.in_ready !== rdy) begin
      errors++;
      $display("FAIL in_ready: got %b expected %b", bus.in_ready, rdy);
    end
    @(posedge clk);
    #1;
    x = q.pop_front();
    checks++;
    if (bus.stage_valid !== x.vld) begin
      errors++;
      $display("FAIL stage_valid: got %b expected %b", bus.stage_valid, x.vld);
    end
    checks++;
    if (bus.stage_data !== x.data) begin
      errors++;
      $display("FAIL stage_data: got %h expected %h", bus.stage_data, x.data);
    end
    checks++;
    if (stall_cnt !== x.sc) begin
      errors++;
      $display("FAIL stall_cnt: got %0d expected %0d", stall_cnt, x.sc);
    end
    checks++;
    if (flush_cnt !== x.fc) begin
      errors++;
      $display("FAIL flush_cnt: got %0d expected %0d", flush_cnt, x.fc);
    end
    checks++;
    if (stall_cnt3 !== x.sc3) begin
      errors++;
      $display("FAIL stall_cnt3: got %0d expected %0d", stall_cnt3, x.sc3);
    end
  endtask

  task automatic drive(input logic rst, input logic run, input logic iv,
                       input logic [DW-1:0] id, input logic [NR-1:0] st,
                       input logic [NR-1:0] fl);
    @(negedge clk);
    reset         = rst;
    run_en        = run;
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.stall_req = st;
    bus.flush_req = fl;
    cycle();
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 4'b0011, 4'b0100);
    checks++;
    if (bus.stage_valid !== 4'b0 || bus.stage_data !== '0 || stall_cnt !== '0 || flush_cnt !== '0) begin
      errors++;
      $display("FAIL reset_state: got v=%b d=%h sc=%0d fc=%0d expected all zero",
               bus.stage_valid, bus.stage_data, stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_streaming();
    drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
    drive(1'b0, 1'b1, 1'b1, 32'h11, '0, '0);
    drive(1'b0, 1'b1, 1'b1, 32'h22, '0, '0);
    drive(1'b0, 1'b1, 1'b1, 32'h33, '0, '0);
    drive(1'b0, 1'b1, 1'b1, 32'h44, '0, '0);
    checks++;
    if (bus.stage_data !== {32'h11, 32'h22, 32'h33, 32'h44} || bus.stage_valid !== 4'hF) begin
      errors++;
      $display("FAIL streaming: got v=%b d=%h expected v=1111 d=11,22,33,44",
               bus.stage_valid, bus.stage_data);
    end
  endtask

  task automatic test_load_use_stall();
    drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
    drive(1'b0, 1'b1, 1'b1, 32'hA1, '0, '0);
    drive(1'b0, 1'b1, 1'b1, 32'hA0, '0, '0);
    drive(1'b0, 1'b1, 1'b1, 32'hCC, 4'b0001, '0);
    checks++;
    if (bus.stage_data[31:0] !== 32'hA0 || bus.stage_data[63:32] !== 32'h0 ||
        bus.stage_valid[1:0] !== 2'b01 || stall_cnt !== 16'd1 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL load_use_stall: got R0=%h R1=%h v=%b sc=%0d rdy=%b expected R0=a0 R1=0 v[1:0]=01 sc=1 rdy=0",
               bus.stage_data[31:0], bus.stage_data[63:32], bus.stage_valid, stall_cnt, bus.in_ready);
    end
    drive(1'b0, 1'b1, 1'b1, 32'hDD, '0, '0);
    checks++;
    if (bus.stage_data[63:32] !== 32'hA0 || bus.stage_data[31:0] !== 32'hDD || bus.stage_valid[1:0] !== 2'b11) begin
      errors++;
      $display("FAIL load_use_release: got R1=%h R0=%h expected R1=a0 R0=dd",
               bus.stage_data[63:32], bus.stage_data[31:0]);
    end
  endtask

  task automatic test_branch_flush();
    drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
    drive(1'b0, 1'b1, 1'b1, 32'hB1, '0, '0);
    drive(1'b0, 1'b1, 1'b1, 32'hB0, '0, '0);
    drive(1'b0, 1'b1, 1'b1, 32'hEE, '0, 4'b0010);
    checks++;
    if (bus.stage_data[63:0] !== 64'h0 || bus.stage_data[95:64] !== 32'hB1 ||
        bus.stage_valid[2:0] !== 3'b100 || flush_cnt !== 16'd1) begin
      errors++;
      $display("FAIL branch_flush: got v=%b d=%h fc=%0d expected v[2:0]=100 R2=b1 fc=1",
               bus.stage_valid, bus.stage_data, flush_cnt);
    end
  endtask

  task automatic test_stall_vs_flush();
    drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
    drive(1'b0, 1'b1, 1'b1, 32'hC3, '0, '0);
    drive(1'b0, 1'b1, 1'b1, 32'hC2, '0, '0);
    drive(1'b0, 1'b1, 1'b1, 32'hC1, '0, '0);
    drive(1'b0, 1'b1, 1'b1, 32'hC0, '0, '0);
    drive(1'b0, 1'b1, 1'b1, 32'hFF, 4'b0100, 4'b0010);
    checks++;
    if (bus.stage_data !== {32'h0, 32'hC2, 32'hC1, 32'hC0} || bus.stage_valid !== 4'b0111 ||
        flush_cnt !== 16'd0 || stall_cnt !== 16'd1) begin
      errors++;
      $display("FAIL stall_wins: got v=%b d=%h sc=%0d fc=%0d expected v=0111 d=0,c2,c1,c0 sc=1 fc=0",
               bus.stage_valid, bus.stage_data, stall_cnt, flush_cnt);
    end
    drive(1'b0, 1'b1, 1'b1, 32'hFE, 4'b0001, 4'b0010);
    checks++;
    if (bus.stage_data !== {32'hC2, 32'hC1, 32'h0, 32'h0} || bus.stage_valid !== 4'b1100 ||
        flush_cnt !== 16'd1 || stall_cnt !== 16'd1) begin
      errors++;
      $display("FAIL flush_wins: got v=%b d=%h sc=%0d fc=%0d expected v=1100 d=c2,c1,0,0 sc=1 fc=1",
               bus.stage_valid, bus.stage_data, stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_halt_and_reset();
    logic [NR*DW-1:0] snap_d;
    logic [NR-1:0]    snap_v;
    logic [CW-1:0]    snap_sc, snap_fc;
    drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
    drive(1'b0, 1'b1, 1'b1, 32'hD3, '0, '0);
    drive(1'b0, 1'b1, 1'b1, 32'hD2, 4'b0001, '0);
    drive(1'b0, 1'b1, 1'b1, 32'hD1, '0, 4'b0001);
    drive(1'b0, 1'b1, 1'b1, 32'hD0, '0, '0);
    snap_d = bus.stage_data;
    snap_v = bus.stage_valid;
    snap_sc = stall_cnt;
    snap_fc = flush_cnt;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b1, $urandom, 4'($urandom_range(1, 15)), 4'($urandom_range(1, 15)));
    end
    checks++;
    if (bus.stage_data !== snap_d || bus.stage_valid !== snap_v || stall_cnt !== snap_sc ||
        flush_cnt !== snap_fc || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL halt_hold: got v=%b d=%h sc=%0d fc=%0d rdy=%b expected v=%b d=%h sc=%0d fc=%0d rdy=0",
               bus.stage_valid, bus.stage_data, stall_cnt, flush_cnt, bus.in_ready,
               snap_v, snap_d, snap_sc, snap_fc);
    end
    drive(1'b0, 1'b1, 1'b1, 32'hE0, 4'b0001, '0);
    drive(1'b1, 1'b1, 1'b1, 32'hE1, 4'b0001, 4'b0010);
    checks++;
    if (bus.stage_valid !== '0 || bus.stage_data !== '0 || stall_cnt !== '0 || flush_cnt !== '0) begin
      errors++;
      $display("FAIL reset_mid_stall: got v=%b d=%h sc=%0d fc=%0d expected all zero",
               bus.stage_valid, bus.stage_data, stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_saturation();
    drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, 1'b1, 32'(i), 4'b0001, '0);
    end
    checks++;
    if (stall_cnt3 !== 3'd7 || stall_cnt !== 16'd10) begin
      errors++;
      $display("FAIL saturation: got sc3=%0d sc=%0d expected sc3=7 sc=10", stall_cnt3, stall_cnt);
    end
  endtask

  task automatic test_random();
    drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 59) == 0),
            ($urandom_range(0, 9) != 0),
            1'($urandom_range(0, 1)),
            $urandom,
            ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0,
            ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.stall_req = '0;
    bus.flush_req = '0;
    for (int k = 0; k < NR; k++) begin
      m_vld[k] = 1'b0;
      m_dat[k] = '0;
    end
    m_sc = 0; m_fc = 0; m_sc3 = 0;
    test_reset();
    test_streaming();
    test_load_use_stall();
    test_branch_flush();
    test_stall_vs_flush();
    test_halt_and_reset();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
